// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/line types and instruction-cache constants
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef enum logic [1:0] {IDLE, FILL, ALLOCATE} icache_state_t;
  localparam int OFFSET_W = 4;
  localparam int WORDS_PER_LINE = 8;
endpackage

// File: rtl/icache_array.sv
// icache_array: per-set valid/tag/data storage, synchronous write, asynchronous read
module icache_array import lc3b_types::*; #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W = $clog2(NUM_SETS),
  parameter int TAG_W = 16 - OFFSET_W - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  lc3b_line         wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output lc3b_line         rdata
);
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];
  lc3b_line            data_q [NUM_SETS];
  // valid bits clear on reset and set when a line is allocated
  always_ff @(posedge clk)
    if (reset) valid_q <= '0;
    else if (load) valid_q[widx] <= 1'b1;
  // tag and data are written on allocation only and never reset
  always_ff @(posedge clk)
    if (load) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];
endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache with zero-cycle hits and L2 line fills
module icache_responder import lc3b_types::*; #(
  parameter int NUM_SETS = 8,
  parameter int LINE_BITS = 128
) (
  input  logic     clk,
  input  logic     reset,
  input  lc3b_word mem_address,
  input  logic     mem_read,
  output lc3b_word mem_rdata,
  output logic     mem_resp,
  output lc3b_word pmem_address,
  output logic     pmem_read,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int LA_W  = 16 - OFFSET_W;
  localparam int TAG_W = LA_W - IDX_W;
  localparam int WS_W  = $clog2(WORDS_PER_LINE);
  icache_state_t        state_q, state_d;
  logic [LA_W-1:0]      line_q, line_d;
  logic [LINE_BITS-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag, rtag;
  logic [WS_W-1:0]      ws;
  logic                 rvalid, hit, unused_bit0;
  lc3b_line             rdata;
  assign idx         = mem_address[OFFSET_W+IDX_W-1:OFFSET_W];
  assign tag         = mem_address[15:OFFSET_W+IDX_W];
  assign ws          = mem_address[OFFSET_W-1:1];
  assign unused_bit0 = mem_address[0];
  icache_array #(.NUM_SETS(NUM_SETS)) u_array (
    .clk(clk),
    .reset(reset),
    .load(state_q == ALLOCATE),
    .widx(line_q[IDX_W-1:0]),
    .wtag(line_q[LA_W-1:IDX_W]),
    .wdata(buf_q),
    .ridx(idx),
    .rvalid(rvalid),
    .rtag(rtag),
    .rdata(rdata)
  );
  assign hit          = state_q == IDLE && mem_read && rvalid && rtag == tag;
  assign mem_resp     = hit;
  assign mem_rdata    = hit ? rdata[{ws, 4'b0} +: 16] : '0;
  assign pmem_read    = state_q == FILL;
  assign pmem_address = {line_q, {OFFSET_W{1'b0}}};
  // next state: latch the line address on a miss, capture L2 data on its response
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    buf_d   = buf_q;
    if (state_q == IDLE && mem_read && !hit) begin
      state_d = FILL;
      line_d  = mem_address[15:OFFSET_W];
    end
    if (state_q == FILL && pmem_resp) begin
      state_d = ALLOCATE;
      buf_d   = pmem_rdata;
    end
    if (state_q == ALLOCATE) state_d = IDLE;
  end
  // state and line address reset; the line buffer holds data only
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
    end
    buf_q <= buf_d;
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: randomized scoreboard bench with a set-level cache model
module tb_icache_responder;
  logic clk = 0, reset = 1;
  logic [15:0] mem_address = 0, mem_rdata, pmem_address;
  logic mem_read = 0, mem_resp, pmem_read, pmem_resp = 0;
  logic [127:0] pmem_rdata = 0;
  int total = 0, bad = 0;
  logic [15:0] expq[$];
  bit mv[8];
  logic [8:0] mt[8];

  icache_responder dut (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    if (a[15:4] == 12'h000) return 16'h1000 + 16'(a[3:1]);
    if (a[15:1] == 15'h7FFF) return 16'hBEEF;
    return (a & 16'hFFFE) ^ 16'h3C3C;
  endfunction

  function automatic logic [127:0] line_of(input logic [15:0] a);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[16*w +: 16] = word_of({a[15:4], 3'(w), 1'b0});
    return l;
  endfunction

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_resp === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp got=%h want=none t=%0t", mem_rdata, $time);
      end else begin
        logic [15:0] e;
        e = expq.pop_front();
        if (mem_rdata !== e) begin
          bad++;
          $display("FAIL rdata got=%h want=%h t=%0t", mem_rdata, e, $time);
        end
      end
    end
  end

  task automatic do_read(input logic [15:0] a, input int lat, input bit drop);
    bit eh;
    eh = mv[a[6:4]] && mt[a[6:4]] == a[15:7];
    if (!drop || eh) expq.push_back(word_of(a));
    mem_address = a;
    mem_read = 1;
    @(negedge clk);
    chk("first_cycle_resp", 16'(mem_resp), 16'(eh));
    chk("first_cycle_pmem_read", 16'(pmem_read), 0);
    if (!eh) begin
      @(posedge clk); #1;
      chk("fill_pmem_read", 16'(pmem_read), 1);
      chk("fill_pmem_addr", pmem_address, {a[15:4], 4'h0});
      if (drop) mem_read = 0;
      for (int i = 1; i < lat; i++) begin
        @(posedge clk); #1;
        chk("fill_hold", 16'(pmem_read), 1);
      end
      pmem_resp = 1;
      pmem_rdata = line_of(a);
      @(posedge clk); #1;
      pmem_resp = 0;
      pmem_rdata = {4{32'hDEAD_BEEF}};
      chk("alloc_pmem_read", 16'(pmem_read), 0);
      chk("alloc_resp", 16'(mem_resp), 0);
      chk("alloc_rdata", mem_rdata, 0);
      mv[a[6:4]] = 1;
      mt[a[6:4]] = a[15:7];
      @(posedge clk); #1;
      @(negedge clk);
      chk("retry_resp", 16'(mem_resp), 16'(!drop));
    end
    @(posedge clk); #1;
    mem_read = 0;
    @(negedge clk);
    chk("idle_resp", 16'(mem_resp), 0);
    chk("idle_rdata", mem_rdata, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_resp", 16'(mem_resp), 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_pmem_read", 16'(pmem_read), 0);
    chk("rst_pmem_addr", pmem_address, 0);
    @(posedge clk); #1;
    reset = 0;
    do_read(16'h0000, 3, 0);
    do_read(16'h0002, 1, 0);
    do_read(16'h000E, 1, 0);
    do_read(16'h0080, 2, 0);
    do_read(16'h0000, 1, 0);
    mem_address = 16'h0120;
    mem_read = 1;
    @(negedge clk);
    chk("rstfill_miss", 16'(mem_resp), 0);
    @(posedge clk); #1;
    chk("rstfill_pmem_read", 16'(pmem_read), 1);
    pmem_resp = 1;
    pmem_rdata = line_of(16'h0120);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    pmem_resp = 0;
    mem_read = 0;
    chk("rstfill_drop", 16'(pmem_read), 0);
    for (int i = 0; i < 8; i++) mv[i] = 0;
    @(posedge clk); #1;
    chk("rstfill_idle", 16'(pmem_read), 0);
    do_read(16'h0120, 2, 0);
    do_read(16'h0002, 1, 0);
    do_read(16'h0036, 2, 1);
    do_read(16'h0036, 1, 0);
    do_read(16'hFFFE, 2, 0);
    for (int n = 0; n < 60; n++)
      do_read(16'($urandom) & 16'h80FE, int'($urandom_range(1, 4)), $urandom_range(0, 7) == 0);
    repeat (2) @(posedge clk);
    chk("queue_drained", 16'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
